// File: rtl/instr_mem_responder_pkg.sv
// ============================================================================
// instr_mem_responder_pkg
// ----------------------------------------------------------------------------
// Shared fetch-stage definitions: responder FSM state encoding, wait-counter
// type, the default idle/invalid instruction word and an address range helper
// used by both the responder and its storage array.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_mem_responder_pkg;

  // Responder FSM states. Encoding kept explicit so waveforms and any
  // downstream decode of the fetch stage stay stable.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } fetch_state_t;

  // Wait counter is sized for the full 0..15 wait-state range.
  localparam int WAIT_CNT_WIDTH = 4;
  typedef logic [WAIT_CNT_WIDTH-1:0] wait_cnt_t;

  // Idle / invalid instruction word presented whenever no response is active.
  localparam logic [15:0] NOP_WORD_DEFAULT = 16'hBF00;

  // True when a (zero-extended) word address falls inside the implemented
  // storage. Addresses are passed as 32 bits so any ADDR_WIDTH up to 32 can
  // be compared against an integer depth without width mismatches.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned depth);
    return addr < depth;
  endfunction

endpackage : instr_mem_responder_pkg

`default_nettype wire

// File: rtl/instr_mem_array.sv
// ============================================================================
// instr_mem_array
// ----------------------------------------------------------------------------
// DEPTH x DATA_WIDTH instruction storage with one synchronous read port and
// one synchronous write port. A write and a read to the same in-range address
// at the same edge return the newly written data (write-first). Writes to
// addresses >= DEPTH are dropped. Contents are not affected by any reset.
//
// Ports:
//   clk      - rising-edge clock
//   rd_en    - read enable; rd_data updates only when set
//   rd_addr  - read word address
//   rd_data  - registered read data
//   wr_en    - write strobe
//   wr_addr  - write word address
//   wr_data  - write data
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_array
  import instr_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  // Index width of the storage itself; DEPTH must not exceed 2**ADDR_WIDTH.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_ok;
  logic             rd_ok;
  logic             bypass;

  assign rd_idx = rd_addr[IDX_W-1:0];
  assign wr_idx = wr_addr[IDX_W-1:0];

  // The range check uses the full address so that an out-of-range address
  // can never alias onto a low index through the truncated rd_idx / wr_idx.
  assign wr_ok  = wr_en & addr_in_range(32'(wr_addr), DEPTH);
  assign rd_ok  = rd_en & addr_in_range(32'(rd_addr), DEPTH);
  assign bypass = wr_ok & (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Write-first: a colliding write is forwarded straight to the read port.
  always_ff @(posedge clk) begin
    if (rd_ok) begin
      rd_data <= bypass ? wr_data : mem[rd_idx];
    end
  end

endmodule : instr_mem_array

`default_nettype wire

// File: rtl/instr_mem_responder.sv
// ============================================================================
// instr_mem_responder
// ----------------------------------------------------------------------------
// Instruction-fetch memory responder. A level-held fetch request is accepted
// in IDLE, the address is latched, WAIT_STATES extra cycles elapse in WAIT,
// the word is read on the last WAIT edge and presented for exactly one
// RESPOND cycle with memory_output_valid. Dropping the request during WAIT
// aborts the access. Out-of-range addresses respond at normal latency with
// NOP_WORD and a one-cycle access_error. A program loader may write the
// array at any time.
//
// Ports:
//   clk                 - rising-edge clock
//   reset               - asynchronous, active-low reset
//   memory_load_request - fetch request, held until served
//   memory_address      - fetch word address
//   load_write_enable   - loader write strobe
//   load_address        - loader word address
//   load_data           - loader write data
//   memory_output_valid - one-cycle response strobe
//   instruction_out     - fetched word (NOP_WORD when not responding)
//   busy                - high in WAIT and RESPOND
//   access_error        - pulses with a response to an address >= DEPTH
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    DEPTH       = 4096,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD    = DATA_WIDTH'(NOP_WORD_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memory_load_request,
  input  logic [ADDR_WIDTH-1:0] memory_address,
  input  logic                  load_write_enable,
  input  logic [ADDR_WIDTH-1:0] load_address,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  memory_output_valid,
  output logic [DATA_WIDTH-1:0] instruction_out,
  output logic                  busy,
  output logic                  access_error
);

  fetch_state_t          state;
  fetch_state_t          state_next;
  wait_cnt_t             wait_cnt;
  wait_cnt_t             wait_cnt_next;
  logic [ADDR_WIDTH-1:0] addr_lat;
  logic [ADDR_WIDTH-1:0] addr_lat_next;
  logic                  valid_next;
  logic                  error_next;
  logic                  rd_en;
  logic                  addr_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  assign addr_ok = addr_in_range(32'(addr_lat), DEPTH);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  instr_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (addr_lat),
    .rd_data (rd_data),
    .wr_en   (load_write_enable),
    .wr_addr (load_address),
    .wr_data (load_data)
  );

  // --------------------------------------------------------------------------
  // FSM state and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= ST_IDLE;
      wait_cnt            <= '0;
      addr_lat            <= '0;
      memory_output_valid <= 1'b0;
      access_error        <= 1'b0;
    end else begin
      state               <= state_next;
      wait_cnt            <= wait_cnt_next;
      addr_lat            <= addr_lat_next;
      memory_output_valid <= valid_next;
      access_error        <= error_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    addr_lat_next = addr_lat;
    rd_en         = 1'b0;
    valid_next    = 1'b0;
    error_next    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (memory_load_request) begin
          addr_lat_next = memory_address;
          wait_cnt_next = wait_cnt_t'(WAIT_STATES);
          state_next    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A withdrawn request wins over completion, even on the last
        // WAIT cycle, so an aborted access never produces a response.
        if (!memory_load_request) begin
          wait_cnt_next = '0;
          state_next    = ST_IDLE;
        end else if (wait_cnt == '0) begin
          // The array is only read for in-range addresses; an
          // out-of-range access still responds, but with NOP_WORD.
          rd_en      = addr_ok;
          valid_next = 1'b1;
          error_next = ~addr_ok;
          state_next = ST_RESPOND;
        end else begin
          wait_cnt_next = wait_cnt - wait_cnt_t'(1);
        end
      end

      ST_RESPOND: begin
        // Always one IDLE cycle before the next acceptance.
        state_next = ST_IDLE;
      end

      default: begin
        state_next    = ST_IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded only from registers, never from inputs. The array read
  // register is the data stage; it is shown only while a valid, in-range
  // response is active and NOP_WORD otherwise.
  // --------------------------------------------------------------------------
  assign busy            = (state != ST_IDLE);
  assign instruction_out = (memory_output_valid && !access_error) ? rd_data : NOP_WORD;

endmodule : instr_mem_responder

`default_nettype wire
